// File: rtl/vram_pkg.sv
// Shared geometry, CSR offsets and FSM state type for the VGA VRAM fill engine.
package vram_pkg;

  localparam int WORDS_PER_ROW = 40;
  localparam int BYTES_PER_ROW = 160;
  localparam int SCREEN_H      = 480;
  localparam int VRAM_WORDS    = 19200;
  localparam logic [14:0] PALETTE_BASE = 15'h4B00;

  localparam logic [1:0] CSR_POS    = 2'd0;
  localparam logic [1:0] CSR_SIZE   = 2'd1;
  localparam logic [1:0] CSR_CTRL   = 2'd2;
  localparam logic [1:0] CSR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_DONE
  } fill_state_t;

  // y*40 as (y<<5)+(y<<3), keeping the row address path multiplier-free
  function automatic logic [14:0] row_base_of(input logic [8:0] y);
    return ({6'b0, y} << 5) + ({6'b0, y} << 3);
  endfunction

endpackage

// File: rtl/vram_fill_master_if.sv
// CSR slave port plus VRAM master port of the fill engine, bundled as one bus.
interface vram_fill_master_if;

  logic        AVL_CS;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic [1:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;
  logic [14:0] M_ADDR;
  logic        M_WRITE;
  logic [3:0]  M_BYTE_EN;
  logic [31:0] M_WRITEDATA;
  logic        M_WAITREQUEST;

  modport master (
    input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA,
    output AVL_READDATA,
    output M_ADDR, M_WRITE, M_BYTE_EN, M_WRITEDATA,
    input  M_WAITREQUEST
  );

  modport slave (
    output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA,
    input  AVL_READDATA,
    input  M_ADDR, M_WRITE, M_BYTE_EN, M_WRITEDATA,
    output M_WAITREQUEST
  );

endinterface

// File: rtl/vram_be_gen.sv
// Byte enables for one VRAM word given an inclusive byte-column span [xb0, xb_end].
module vram_be_gen (
  input  logic [5:0] word,
  input  logic [7:0] xb0,
  input  logic [7:0] xb_end,
  output logic [3:0] be
);

  // Byte p of the word is the leftmost-first column word*4+p and maps to BE bit 3-p
  for (genvar p = 0; p < 4; p++) begin : g_byte
    logic [7:0] pos;
    assign pos       = {word, 2'(p)};
    assign be[3 - p] = (pos >= xb0) && (pos <= xb_end);
  end

endmodule

// File: rtl/vram_fill_master.sv
// Rectangle-fill engine: CPU programs a byte-granular rectangle over the CSR port,
// the block then streams byte-enabled pattern words into VRAM as an Avalon master.
module vram_fill_master
  import vram_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  vram_fill_master_if.master  bus,
  output logic                IRQ
);

  fill_state_t state, next_state;

  logic [7:0]  pos_xb0, size_wb;
  logic [8:0]  pos_y0, size_h;
  logic [1:0]  color;
  logic        irq_en, done, error;

  logic [7:0]  w_xb0, w_xb_end;
  logic [8:0]  w_y0, rows_left;
  logic [1:0]  w_color;
  logic [14:0] row_base;
  logic [5:0]  word_idx, end_word;
  logic        first_row;

  logic        csr_wr, start_req, geom_bad, last_word, accept, m_write, busy;
  logic [3:0]  be;
  logic        unused_wd_bits;

  assign csr_wr    = bus.AVL_CS && bus.AVL_WRITE;
  assign start_req = csr_wr && (bus.AVL_ADDR == CSR_CTRL) && bus.AVL_WRITEDATA[0]
                     && (state == ST_IDLE);
  assign geom_bad  = (size_wb == 8'd0) || (size_h == 9'd0)
                     || (({1'b0, pos_xb0} + {1'b0, size_wb}) > 9'(BYTES_PER_ROW))
                     || (({1'b0, pos_y0} + {1'b0, size_h}) > 10'(SCREEN_H));
  assign last_word = (word_idx == end_word);
  assign accept    = (state == ST_WRITE) && !bus.M_WAITREQUEST;
  assign busy      = (state != ST_IDLE);
  assign unused_wd_bits = ^{bus.AVL_WRITEDATA[31:25], bus.AVL_WRITEDATA[15:9]};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    m_write    = 1'b0;
    case (state)
      ST_IDLE:  if (start_req && !geom_bad) next_state = ST_SETUP;
      ST_SETUP: next_state = ST_WRITE;
      ST_WRITE: begin
        m_write = 1'b1;
        if (accept && last_word)
          next_state = (rows_left == 9'd1) ? ST_DONE : ST_SETUP;
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // CSR registers, working copies latched at start, and the row/word walkers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pos_xb0   <= '0;
      pos_y0    <= '0;
      size_wb   <= '0;
      size_h    <= '0;
      color     <= '0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      w_xb0     <= '0;
      w_xb_end  <= '0;
      w_y0      <= '0;
      w_color   <= '0;
      rows_left <= '0;
      row_base  <= '0;
      word_idx  <= '0;
      end_word  <= '0;
      first_row <= 1'b0;
      IRQ       <= 1'b0;
    end else begin
      if (csr_wr) begin
        case (bus.AVL_ADDR)
          CSR_POS: begin
            pos_y0  <= bus.AVL_WRITEDATA[24:16];
            pos_xb0 <= bus.AVL_WRITEDATA[7:0];
          end
          CSR_SIZE: begin
            size_h  <= bus.AVL_WRITEDATA[24:16];
            size_wb <= bus.AVL_WRITEDATA[7:0];
          end
          CSR_CTRL: begin
            color  <= bus.AVL_WRITEDATA[5:4];
            irq_en <= bus.AVL_WRITEDATA[8];
          end
          default: begin
            if (bus.AVL_WRITEDATA[1]) begin
              done  <= 1'b0;
              error <= 1'b0;
            end
          end
        endcase
      end

      if (start_req) begin
        done  <= geom_bad;
        error <= geom_bad;
        if (!geom_bad) begin
          w_xb0     <= pos_xb0;
          w_xb_end  <= pos_xb0 + size_wb - 8'd1;
          w_y0      <= pos_y0;
          w_color   <= bus.AVL_WRITEDATA[5:4];
          rows_left <= size_h;
          first_row <= 1'b1;
        end
      end

      if (state == ST_SETUP) begin
        word_idx  <= w_xb0[7:2];
        end_word  <= w_xb_end[7:2];
        row_base  <= first_row ? row_base_of(w_y0) : row_base + 15'(WORDS_PER_ROW);
        first_row <= 1'b0;
      end

      if (accept) begin
        if (last_word) rows_left <= rows_left - 9'd1;
        else           word_idx  <= word_idx + 6'd1;
      end

      if (accept && last_word && (rows_left == 9'd1)) done <= 1'b1;

      IRQ <= done && irq_en;
    end
  end

  vram_be_gen u_be_gen (
    .word   (word_idx),
    .xb0    (w_xb0),
    .xb_end (w_xb_end),
    .be     (be)
  );

  assign bus.M_WRITE     = m_write;
  assign bus.M_ADDR      = row_base + {9'b0, word_idx};
  assign bus.M_BYTE_EN   = m_write ? be : 4'b0000;
  assign bus.M_WRITEDATA = {16{w_color}};

  always_comb begin
    bus.AVL_READDATA = '0;
    if (bus.AVL_CS && bus.AVL_READ) begin
      case (bus.AVL_ADDR)
        CSR_POS:  bus.AVL_READDATA = {7'b0, pos_y0, 8'b0, pos_xb0};
        CSR_SIZE: bus.AVL_READDATA = {7'b0, size_h, 8'b0, size_wb};
        default:  bus.AVL_READDATA = {23'b0, irq_en, 2'b0, color, 1'b0, error, done, busy};
      endcase
    end
  end

endmodule

// File: tb/tb_vram_fill_master.sv
// Directed bench for vram_fill_master: a table of rectangles with hand-computed
// write counts, addresses, enables and busy lengths, plus multi-cycle corner cases.
module tb_vram_fill_master;
  import vram_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  logic IRQ;

  vram_fill_master_if bus ();

  vram_fill_master dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus),
    .IRQ   (IRQ)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    logic [7:0]  xb0;
    logic [8:0]  y0;
    logic [7:0]  wb;
    logic [8:0]  h;
    logic [1:0]  color;
    logic        exp_err;
    int          exp_writes;
    logic [14:0] first_addr;
    logic [3:0]  first_be;
    logic [14:0] last_addr;
    logic [3:0]  last_be;
    int          exp_busy;
  } vec_t;

  vec_t vecs [10];

  int n_compared   = 0;
  int n_mismatched = 0;

  int write_cycles, accepted, busy_cycles, data_bad, hold_bad, held_count;
  int stall_index, stall_cycles, stall_used;
  logic [31:0] exp_data;
  logic [14:0] addr_q [$];
  logic [3:0]  be_q [$];
  logic        held_valid;
  logic [14:0] held_addr;
  logic [3:0]  held_be;
  logic [31:0] held_data;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Slave model: decides the stall for this cycle, then logs what the DUT drives
  always @(negedge CLK) begin
    if (RESET) begin
      bus.M_WAITREQUEST = 1'b0;
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        held_count++;
        if (!bus.M_WRITE || bus.M_ADDR !== held_addr || bus.M_BYTE_EN !== held_be
            || bus.M_WRITEDATA !== held_data)
          hold_bad++;
        held_valid = 1'b0;
      end
      bus.M_WAITREQUEST = bus.M_WRITE && (accepted == stall_index) && (stall_used < stall_cycles);
      if (bus.M_WAITREQUEST) begin
        stall_used++;
        held_valid = 1'b1;
        held_addr  = bus.M_ADDR;
        held_be    = bus.M_BYTE_EN;
        held_data  = bus.M_WRITEDATA;
      end
      if (bus.AVL_READDATA[0]) busy_cycles++;
      if (bus.M_WRITE) begin
        write_cycles++;
        if (bus.M_WRITEDATA !== exp_data) data_bad++;
        if (!bus.M_WAITREQUEST) begin
          accepted++;
          addr_q.push_back(bus.M_ADDR);
          be_q.push_back(bus.M_BYTE_EN);
        end
      end
    end
  end

  task automatic reset_counters();
    write_cycles = 0; accepted = 0; busy_cycles = 0; data_bad = 0;
    hold_bad = 0; held_count = 0; stall_index = -1; stall_cycles = 0; stall_used = 0;
    addr_q.delete();
    be_q.delete();
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge CLK); #1;
    bus.AVL_ADDR = a; bus.AVL_WRITEDATA = d; bus.AVL_WRITE = 1'b1;
    @(posedge CLK); #1;
    bus.AVL_WRITE = 1'b0; bus.AVL_ADDR = CSR_CTRL; bus.AVL_WRITEDATA = '0;
  endtask

  task automatic start_fill(input logic [7:0] xb0, input logic [8:0] y0,
                            input logic [7:0] wb, input logic [8:0] h,
                            input logic [1:0] color, input logic irq,
                            input int st_idx, input int st_n);
    csr_write(CSR_POS,    {7'b0, y0, 8'b0, xb0});
    csr_write(CSR_SIZE,   {7'b0, h, 8'b0, wb});
    csr_write(CSR_STATUS, 32'h2);
    reset_counters();
    stall_index  = st_idx;
    stall_cycles = st_n;
    exp_data     = {16{color}};
    csr_write(CSR_CTRL, {23'b0, irq, 2'b0, color, 4'b0001});
  endtask

  task automatic wait_done(input string name, input int budget);
    bit fin = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (bus.AVL_READDATA[1] && !bus.AVL_READDATA[0]) begin
        fin = 1'b1;
        break;
      end
    end
    check_output({name, " completes"}, 32'(fin), 32'd1);
    @(posedge CLK); #1;
  endtask

  task automatic apply_stimulus(input int i, input vec_t v);
    start_fill(v.xb0, v.y0, v.wb, v.h, v.color, 1'b0, -1, 0);
    wait_done($sformatf("v%0d", i), 25000);
  endtask

  task automatic check_vector(input int i, input vec_t v);
    check_output($sformatf("v%0d error", i),  32'(bus.AVL_READDATA[2]), 32'(v.exp_err));
    check_output($sformatf("v%0d done", i),   32'(bus.AVL_READDATA[1]), 32'd1);
    check_output($sformatf("v%0d writes", i), 32'(write_cycles), 32'(v.exp_writes));
    check_output($sformatf("v%0d busy", i),   32'(busy_cycles),  32'(v.exp_busy));
    check_output($sformatf("v%0d data", i),   32'(data_bad),     32'd0);
    if (!v.exp_err) begin
      check_output($sformatf("v%0d first addr", i), 32'(addr_q[0]), 32'(v.first_addr));
      check_output($sformatf("v%0d first be", i),   32'(be_q[0]),   32'(v.first_be));
      check_output($sformatf("v%0d last addr", i),  32'(addr_q[addr_q.size()-1]), 32'(v.last_addr));
      check_output($sformatf("v%0d last be", i),    32'(be_q[be_q.size()-1]),     32'(v.last_be));
    end
  endtask

  initial begin
    logic [14:0] exp_a [6];
    logic [3:0]  exp_b [6];
    int k_write, k_done, k_irq;

    vecs[0] = '{8'd0,   9'd0,   8'd1,   9'd1,   2'd2, 1'b0, 1,     15'd0,     4'b1000, 15'd0,     4'b1000, 3};
    vecs[1] = '{8'd3,   9'd10,  8'd6,   9'd2,   2'd1, 1'b0, 6,     15'd400,   4'b0001, 15'd442,   4'b1000, 9};
    vecs[2] = '{8'd150, 9'd0,   8'd20,  9'd1,   2'd0, 1'b1, 0,     15'd0,     4'b0000, 15'd0,     4'b0000, 0};
    vecs[3] = '{8'd0,   9'd0,   8'd4,   9'd0,   2'd0, 1'b1, 0,     15'd0,     4'b0000, 15'd0,     4'b0000, 0};
    vecs[4] = '{8'd158, 9'd479, 8'd2,   9'd1,   2'd3, 1'b0, 1,     15'd19199, 4'b0011, 15'd19199, 4'b0011, 3};
    vecs[5] = '{8'd0,   9'd479, 8'd1,   9'd2,   2'd1, 1'b1, 0,     15'd0,     4'b0000, 15'd0,     4'b0000, 0};
    vecs[6] = '{8'd5,   9'd1,   8'd2,   9'd3,   2'd0, 1'b0, 3,     15'd41,    4'b0110, 15'd121,   4'b0110, 7};
    vecs[7] = '{8'd1,   9'd100, 8'd159, 9'd1,   2'd2, 1'b0, 40,    15'd4000,  4'b0111, 15'd4039,  4'b1111, 42};
    vecs[8] = '{8'd159, 9'd0,   8'd2,   9'd1,   2'd1, 1'b1, 0,     15'd0,     4'b0000, 15'd0,     4'b0000, 0};
    vecs[9] = '{8'd0,   9'd0,   8'd160, 9'd480, 2'd3, 1'b0, 19200, 15'd0,     4'b1111, 15'd19199, 4'b1111, 19681};

    bus.AVL_CS = 1'b1; bus.AVL_READ = 1'b1; bus.AVL_WRITE = 1'b0;
    bus.AVL_ADDR = CSR_CTRL; bus.AVL_WRITEDATA = '0;
    exp_data = '0;
    reset_counters();
    RESET = 1'b1;
    #35;
    check_output("reset M_WRITE",     32'(bus.M_WRITE),     32'd0);
    check_output("reset M_ADDR",      32'(bus.M_ADDR),      32'd0);
    check_output("reset M_BYTE_EN",   32'(bus.M_BYTE_EN),   32'd0);
    check_output("reset M_WRITEDATA", bus.M_WRITEDATA,      32'd0);
    check_output("reset IRQ",         32'(IRQ),             32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus.AVL_ADDR = 2'(a);
      #1;
      check_output($sformatf("reset csr%0d", a), bus.AVL_READDATA, 32'd0);
    end
    bus.AVL_ADDR = CSR_CTRL;

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(i, vecs[i]);
      check_vector(i, vecs[i]);
    end

    // Second write of the two-row rectangle stalls for three cycles
    exp_a = '{15'd400, 15'd401, 15'd402, 15'd440, 15'd441, 15'd442};
    exp_b = '{4'b0001, 4'b1111, 4'b1000, 4'b0001, 4'b1111, 4'b1000};
    start_fill(8'd3, 9'd10, 8'd6, 9'd2, 2'd1, 1'b0, 1, 3);
    wait_done("stall", 200);
    check_output("stall accepted", 32'(addr_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_output($sformatf("stall addr%0d", i), 32'(addr_q[i]), 32'(exp_a[i]));
      check_output($sformatf("stall be%0d", i),   32'(be_q[i]),   32'(exp_b[i]));
    end
    check_output("stall write cycles", 32'(write_cycles), 32'd9);
    check_output("stall busy",         32'(busy_cycles),  32'd12);
    check_output("stall held cycles",  32'(held_count),   32'd3);
    check_output("stall hold stable",  32'(hold_bad),     32'd0);

    // First M_WRITE at N+2, done at N+3, IRQ at N+4
    start_fill(8'd0, 9'd0, 8'd1, 9'd1, 2'd2, 1'b1, -1, 0);
    k_write = 0; k_done = 0; k_irq = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (bus.M_WRITE && k_write == 0)          k_write = k;
      if (bus.AVL_READDATA[1] && k_done == 0)   k_done = k;
      if (IRQ && k_irq == 0)                    k_irq = k;
    end
    check_output("irq first write cycle", 32'(k_write), 32'd2);
    check_output("irq done cycle",        32'(k_done),  32'd3);
    check_output("irq rise cycle",        32'(k_irq),   32'd4);
    check_output("irq_en readback",       32'(bus.AVL_READDATA[8]), 32'd1);
    csr_write(CSR_STATUS, 32'h2);
    @(posedge CLK); #1;
    check_output("irq cleared",  32'(IRQ), 32'd0);
    check_output("done cleared", 32'(bus.AVL_READDATA[1]), 32'd0);
    csr_write(CSR_CTRL, 32'h0);

    // Start and POS write while busy must not disturb the running fill
    start_fill(8'd0, 9'd0, 8'd160, 9'd1, 2'd2, 1'b0, -1, 0);
    repeat (5) @(posedge CLK);
    csr_write(CSR_POS, 32'h0005_0000);
    csr_write(CSR_CTRL, 32'h11);
    wait_done("busy start", 200);
    check_output("busy start writes",    32'(write_cycles), 32'd40);
    check_output("busy start last addr", 32'(addr_q[addr_q.size()-1]), 32'd39);
    check_output("busy start data",      32'(data_bad), 32'd0);
    reset_counters();
    exp_data = 32'h5555_5555;
    csr_write(CSR_CTRL, 32'h11);
    wait_done("deferred pos", 200);
    check_output("deferred pos first addr", 32'(addr_q[0]), 32'd200);
    check_output("deferred pos writes",     32'(write_cycles), 32'd40);
    check_output("deferred pos data",       32'(data_bad), 32'd0);

    // Reset in the middle of a fill
    start_fill(8'd0, 9'd0, 8'd160, 9'd10, 2'd1, 1'b0, -1, 0);
    repeat (10) @(posedge CLK);
    #3;
    check_output("pre-reset M_WRITE", 32'(bus.M_WRITE), 32'd1);
    RESET = 1'b1;
    #1;
    check_output("mid reset M_WRITE",   32'(bus.M_WRITE),   32'd0);
    check_output("mid reset M_BYTE_EN", 32'(bus.M_BYTE_EN), 32'd0);
    check_output("mid reset busy",      32'(bus.AVL_READDATA[0]), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    apply_stimulus(1, vecs[1]);
    check_vector(1, vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
